// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit I/O device bus between the 68K and the Z80 window.
// Grant counters M_CNT/Z_CNT are built only when IO_ARB_STATS_EN is defined; otherwise they read 0.
module io_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        M_SEL,
  input  logic [3:0]  M_A,
  input  logic        M_RNW,
  input  logic [7:0]  M_DI,
  output logic [7:0]  M_DO,
  output logic        M_DTACK_N,
  input  logic        Z_SEL,
  input  logic [3:0]  Z_A,
  input  logic        Z_RNW,
  input  logic [7:0]  Z_DI,
  output logic [7:0]  Z_DO,
  output logic        Z_DTACK_N,
  output logic        IO_SEL,
  output logic [3:0]  IO_A,
  output logic        IO_RNW,
  output logic [7:0]  IO_DO,
  input  logic [7:0]  IO_DI,
  input  logic        IO_DTACK_N,
  output logic        TO_ERR,
  output logic        GNT_Z,
  output logic [15:0] M_CNT,
  output logic [15:0] Z_CNT
);

  // state | meaning
  // IDLE  | no device cycle; pick a pending requester on CE
  // BUSY  | IO_SEL high, waiting for device ack or timeout
  // DRAIN | IO_SEL low, waiting for the device to release DTACK
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic          owner_z;
  logic          m_served, z_served;
  logic          m_pend, z_pend;
  logic          grant_m, grant_z, tie, ack, tmo, done;
  logic          m_deliver, z_deliver;

  assign m_pend = M_SEL && M_DTACK_N && !m_served;
  assign z_pend = Z_SEL && Z_DTACK_N && !z_served;
  assign done   = ack || tmo;

  // An owner that dropped SEL (even if it re-raised it) lost its served flag and gets no ack.
  assign m_deliver = done && !owner_z && M_SEL && m_served;
  assign z_deliver = done &&  owner_z && Z_SEL && z_served;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_m    = 1'b0;
    grant_z    = 1'b0;
    tie        = 1'b0;
    ack        = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: if (CE) begin
        if (m_pend && z_pend) begin
          tie     = 1'b1;
          grant_m = GNT_Z;
          grant_z = ~GNT_Z;
        end else begin
          grant_m = m_pend;
          grant_z = z_pend;
        end
        if (m_pend || z_pend) state_next = BUSY;
      end
      BUSY: if (CE) begin
        ack = ~IO_DTACK_N;
        tmo = IO_DTACK_N && (timer == TO_LAST);
        if (ack || tmo) state_next = DRAIN;
      end
      DRAIN: if (CE && IO_DTACK_N) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      M_DO      <= 8'hFF;
      Z_DO      <= 8'hFF;
      M_DTACK_N <= 1'b1;
      Z_DTACK_N <= 1'b1;
      IO_SEL    <= 1'b0;
      IO_A      <= '0;
      IO_RNW    <= 1'b1;
      IO_DO     <= 8'hFF;
      TO_ERR    <= 1'b0;
      GNT_Z     <= 1'b1;
      owner_z   <= 1'b0;
      m_served  <= 1'b0;
      z_served  <= 1'b0;
      timer     <= '0;
    end else if (CE) begin
      TO_ERR <= tmo;
      // GNT_Z only flips when a tie is broken, so alternation holds across contended pairs.
      if (tie) GNT_Z <= ~GNT_Z;
      if (grant_m || grant_z) begin
        owner_z <= grant_z;
        IO_SEL  <= 1'b1;
        IO_A    <= grant_z ? Z_A   : M_A;
        IO_RNW  <= grant_z ? Z_RNW : M_RNW;
        IO_DO   <= grant_z ? Z_DI  : M_DI;
        timer   <= '0;
      end else if (state == BUSY) begin
        timer <= timer + 1'b1;
      end
      if (done) IO_SEL <= 1'b0;
      if (grant_m) m_served <= 1'b1;
      if (grant_z) z_served <= 1'b1;
      if (m_deliver) begin
        M_DTACK_N <= 1'b0;
        if (IO_RNW) M_DO <= ack ? IO_DI : 8'hFF;
      end
      if (z_deliver) begin
        Z_DTACK_N <= 1'b0;
        if (IO_RNW) Z_DO <= ack ? IO_DI : 8'hFF;
      end
      if (!M_SEL) begin
        M_DTACK_N <= 1'b1;
        m_served  <= 1'b0;
      end
      if (!Z_SEL) begin
        Z_DTACK_N <= 1'b1;
        z_served  <= 1'b0;
      end
    end
  end

`ifdef IO_ARB_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      M_CNT <= '0;
      Z_CNT <= '0;
    end else begin
      if (grant_m && M_CNT != 16'hFFFF) M_CNT <= M_CNT + 16'd1;
      if (grant_z && Z_CNT != 16'hFFFF) Z_CNT <= Z_CNT + 16'd1;
    end
  end
`else
  assign M_CNT = '0;
  assign Z_CNT = '0;
`endif

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: device model, scoreboard queues for device cycles and acks.
module tb_io_bus_arbiter;

  logic        CLK, RESET, CE;
  logic        M_SEL, M_RNW, M_DTACK_N;
  logic [3:0]  M_A;
  logic [7:0]  M_DI, M_DO;
  logic        Z_SEL, Z_RNW, Z_DTACK_N;
  logic [3:0]  Z_A;
  logic [7:0]  Z_DI, Z_DO;
  logic        IO_SEL, IO_RNW, IO_DTACK_N;
  logic [3:0]  IO_A;
  logic [7:0]  IO_DO, IO_DI;
  logic        TO_ERR, GNT_Z;
  logic [15:0] M_CNT, Z_CNT;

  io_bus_arbiter #(.TIMEOUT(4), .TW(8)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .M_SEL(M_SEL), .M_A(M_A), .M_RNW(M_RNW), .M_DI(M_DI), .M_DO(M_DO), .M_DTACK_N(M_DTACK_N),
    .Z_SEL(Z_SEL), .Z_A(Z_A), .Z_RNW(Z_RNW), .Z_DI(Z_DI), .Z_DO(Z_DO), .Z_DTACK_N(Z_DTACK_N),
    .IO_SEL(IO_SEL), .IO_A(IO_A), .IO_RNW(IO_RNW), .IO_DO(IO_DO), .IO_DI(IO_DI),
    .IO_DTACK_N(IO_DTACK_N), .TO_ERR(TO_ERR), .GNT_Z(GNT_Z), .M_CNT(M_CNT), .Z_CNT(Z_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] a;
    logic       rnw;
    logic [7:0] d;
  } io_t;

  io_t        io_q[$];
  logic [7:0] m_q[$];
  logic [7:0] z_q[$];

  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_grants = 0;
  int         z_grants = 0;
  logic [7:0] m_model = 8'hFF;
  logic [7:0] z_model = 8'hFF;
  logic       io_sel_q = 1'b0;
  logic       m_dtack_q = 1'b1;
  logic       z_dtack_q = 1'b1;

  logic       dev_en = 1'b1;
  int         dev_lat = 1;
  int         dev_cnt = 0;
  logic [7:0] dev_data = 8'h00;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: device cycles are checked when IO_SEL rises, read data when a DTACK_N falls.
  task automatic monitor();
    io_t        e;
    logic [7:0] d;
    if (IO_SEL && !io_sel_q) begin
      chk1("io_q_nonempty", io_q.size() != 0, 1'b1);
      if (io_q.size() != 0) begin
        e = io_q.pop_front();
        chk4("io_a", IO_A, e.a);
        chk1("io_rnw", IO_RNW, e.rnw);
        chk8("io_do", IO_DO, e.d);
      end
    end
    if (!M_DTACK_N && m_dtack_q) begin
      chk1("m_q_nonempty", m_q.size() != 0, 1'b1);
      if (m_q.size() != 0) begin
        d = m_q.pop_front();
        chk8("m_do", M_DO, d);
      end
    end
    if (!Z_DTACK_N && z_dtack_q) begin
      chk1("z_q_nonempty", z_q.size() != 0, 1'b1);
      if (z_q.size() != 0) begin
        d = z_q.pop_front();
        chk8("z_do", Z_DO, d);
      end
    end
    io_sel_q  = IO_SEL;
    m_dtack_q = M_DTACK_N;
    z_dtack_q = Z_DTACK_N;
  endtask

  // One clock; the device acks dev_lat CEs after it first samples SEL high.
  task automatic tick();
    logic sel_s, ce_s;
    sel_s = IO_SEL;
    ce_s  = CE;
    @(posedge CLK);
    #1;
    if (ce_s) begin
      if (!sel_s) begin
        dev_cnt    = 0;
        IO_DTACK_N = 1'b1;
      end else if (dev_en) begin
        dev_cnt++;
        if (dev_cnt >= dev_lat) begin
          IO_DTACK_N = 1'b0;
          IO_DI      = dev_data;
        end
      end
    end
    monitor();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic m_req(input logic [3:0] a, input logic rnw, input logic [7:0] di,
                       input logic [7:0] rd, input logic expect_ack);
    io_t e;
    M_A = a; M_RNW = rnw; M_DI = di; M_SEL = 1'b1;
    e.a = a; e.rnw = rnw; e.d = di;
    io_q.push_back(e);
    if (expect_ack) begin
      if (rnw) m_model = rd;
      m_q.push_back(m_model);
    end
    m_grants++;
  endtask

  task automatic z_req(input logic [3:0] a, input logic rnw, input logic [7:0] di,
                       input logic [7:0] rd);
    io_t e;
    Z_A = a; Z_RNW = rnw; Z_DI = di; Z_SEL = 1'b1;
    e.a = a; e.rnw = rnw; e.d = di;
    io_q.push_back(e);
    if (rnw) z_model = rd;
    z_q.push_back(z_model);
    z_grants++;
  endtask

  task automatic wait_m_ack(input int budget);
    for (int i = 0; i < budget && M_DTACK_N; i++) tick();
    chk1("m_ack_wait", M_DTACK_N, 1'b0);
  endtask

  task automatic wait_z_ack(input int budget);
    for (int i = 0; i < budget && Z_DTACK_N; i++) tick();
    chk1("z_ack_wait", Z_DTACK_N, 1'b0);
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b1;
    M_SEL = 1'b0; M_A = '0; M_RNW = 1'b1; M_DI = '0;
    Z_SEL = 1'b0; Z_A = '0; Z_RNW = 1'b1; Z_DI = '0;
    IO_DI = 8'h00; IO_DTACK_N = 1'b1;
    idle(3);
    chk8("rst_m_do", M_DO, 8'hFF);
    chk8("rst_z_do", Z_DO, 8'hFF);
    chk1("rst_m_dtack", M_DTACK_N, 1'b1);
    chk1("rst_z_dtack", Z_DTACK_N, 1'b1);
    chk1("rst_io_sel", IO_SEL, 1'b0);
    chk4("rst_io_a", IO_A, 4'h0);
    chk1("rst_io_rnw", IO_RNW, 1'b1);
    chk8("rst_io_do", IO_DO, 8'hFF);
    chk1("rst_to_err", TO_ERR, 1'b0);
    chk1("rst_gnt_z", GNT_Z, 1'b1);
    chk16("rst_m_cnt", M_CNT, 16'h0);
    chk16("rst_z_cnt", Z_CNT, 16'h0);
    RESET = 1'b0;
    idle(2);

    // 68K read, device acks 2 CE after IO_SEL with 5A
    dev_lat = 1; dev_data = 8'h5A;
    m_req(4'h3, 1'b1, 8'h00, 8'h5A, 1'b1);
    tick();
    chk1("t1_sel_latency", IO_SEL, 1'b1);
    tick();
    chk1("t1_dtack_wait", M_DTACK_N, 1'b1);
    tick();
    chk1("t1_dtack_low", M_DTACK_N, 1'b0);
    chk1("t1_io_sel_low", IO_SEL, 1'b0);
    chk1("t1_gnt_z", GNT_Z, 1'b1);
    M_SEL = 1'b0;
    tick();
    chk1("t1_dtack_release", M_DTACK_N, 1'b1);
    idle(3);

    // simultaneous pair after reset: 68K first
    dev_lat = 1; dev_data = 8'h11;
    m_req(4'h1, 1'b1, 8'h00, 8'h11, 1'b1);
    z_req(4'h5, 1'b0, 8'h77, 8'h00);
    tick();
    chk1("p1_gnt_z", GNT_Z, 1'b0);
    wait_m_ack(8);
    chk1("p1_z_waits", Z_DTACK_N, 1'b1);
    M_SEL = 1'b0;
    wait_z_ack(10);
    chk8("p1_z_write_keeps_do", Z_DO, 8'hFF);
    Z_SEL = 1'b0;
    idle(3);
    chk1("p1_gnt_z_after", GNT_Z, 1'b0);

    // second simultaneous pair: Z80 first
    dev_data = 8'h9C;
    z_req(4'h7, 1'b1, 8'h00, 8'h9C);
    m_req(4'h6, 1'b0, 8'h12, 8'h00, 1'b1);
    tick();
    chk1("p2_gnt_z", GNT_Z, 1'b1);
    wait_z_ack(8);
    chk1("p2_m_waits", M_DTACK_N, 1'b1);
    Z_SEL = 1'b0;
    wait_m_ack(10);
    M_SEL = 1'b0;
    idle(3);

    // Z80 write queued behind a busy 68K read
    dev_lat = 2; dev_data = 8'hA5;
    m_req(4'hB, 1'b1, 8'h00, 8'hA5, 1'b1);
    tick();
    z_req(4'h4, 1'b0, 8'h40, 8'h00);
    for (int i = 0; i < 8 && M_DTACK_N; i++) begin
      tick();
      chk1("t3_z_dtack_held", Z_DTACK_N, 1'b1);
      chk4("t3_io_a_owner", IO_A, 4'hB);
    end
    chk1("t3_m_acked", M_DTACK_N, 1'b0);
    M_SEL = 1'b0;
    wait_z_ack(10);
    Z_SEL = 1'b0;
    idle(3);

    // absent device: timeout on the 4th CE of BUSY
    dev_en = 1'b0;
    m_req(4'h9, 1'b1, 8'h00, 8'hFF, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("t4_no_to_early", TO_ERR, 1'b0);
      chk1("t4_dtack_early", M_DTACK_N, 1'b1);
    end
    tick();
    chk1("t4_to_err", TO_ERR, 1'b1);
    chk1("t4_dtack", M_DTACK_N, 1'b0);
    M_SEL = 1'b0;
    tick();
    chk1("t4_to_pulse_end", TO_ERR, 1'b0);
    dev_en = 1'b1; dev_lat = 1; dev_data = 8'h5C;
    z_req(4'h8, 1'b1, 8'h00, 8'h5C);
    tick();
    chk1("t4_back_to_idle", IO_SEL, 1'b1);
    wait_z_ack(8);
    Z_SEL = 1'b0;
    idle(3);

    // 68K aborts mid-BUSY; device acks later with 33
    dev_lat = 2; dev_data = 8'h33;
    m_req(4'h2, 1'b1, 8'h00, 8'h33, 1'b0);
    idle(2);
    M_SEL = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("t5_dtack_held", M_DTACK_N, 1'b1);
      chk8("t5_do_kept", M_DO, m_model);
    end
    chk1("t5_io_sel_low", IO_SEL, 1'b0);

    // CE low freezes the arbiter
    dev_lat = 1;
    CE = 1'b0;
    z_req(4'h1, 1'b0, 8'hC3, 8'h00);
    tick();
    chk1("ce_hold_0", IO_SEL, 1'b0);
    tick();
    chk1("ce_hold_1", IO_SEL, 1'b0);
    CE = 1'b1;
    tick();
    chk1("ce_resume", IO_SEL, 1'b1);
    wait_z_ack(8);
    Z_SEL = 1'b0;
    idle(3);

`ifdef IO_ARB_STATS_EN
    chk16("m_cnt", M_CNT, 16'(m_grants));
    chk16("z_cnt", Z_CNT, 16'(z_grants));
`else
    chk16("m_cnt_off", M_CNT, 16'h0);
    chk16("z_cnt_off", Z_CNT, 16'h0);
`endif

    // asynchronous reset in the middle of a device cycle
    dev_lat = 4;
    m_req(4'hE, 1'b0, 8'h55, 8'h00, 1'b1);
    idle(2);
    chk1("t6_busy", IO_SEL, 1'b1);
    #2;
    RESET = 1'b1;
    #1;
    chk1("t6_io_sel", IO_SEL, 1'b0);
    chk1("t6_m_dtack", M_DTACK_N, 1'b1);
    chk1("t6_z_dtack", Z_DTACK_N, 1'b1);
    chk8("t6_io_do", IO_DO, 8'hFF);
    chk8("t6_m_do", M_DO, 8'hFF);
    chk16("t6_m_cnt", M_CNT, 16'h0);
    chk16("t6_z_cnt", Z_CNT, 16'h0);
    m_q.delete();
    M_SEL = 1'b0;
    idle(2);
    RESET = 1'b0;
    idle(2);
    chk1("io_q_drained", io_q.size() == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
